// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// operation codes, default BUSY timeout and BUSY-counter geometry.
package multdiv_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int TIMEOUT_DEFAULT = 48;

   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/md_cycle_counter.sv
// Saturating up-counter of BUSY cycles. Synchronous clear has priority over
// enable; the count holds at its maximum value instead of wrapping.
module md_cycle_counter
   import multdiv_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise step while enabled and not saturated.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequencer between an issue stage, an iterative multiply/divide unit and a
// writeback stage. States: IDLE -> START (one-cycle start pulse) -> BUSY
// (wait for the unit) -> DONE (hold result until written back).
// Optional feature: define MULTDIV_TIMEOUT_EN to abort BUSY after TIMEOUT
// cycles with wb_result = 0 and wb_exception = 1.
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   // issue side
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic             issue_op,
   input  logic [31:0]      issue_a,
   input  logic [31:0]      issue_b,
   input  logic [4:0]       issue_rd,
   input  logic             flush,
   // multiply/divide unit side
   output logic             md_ctrl_MULT,
   output logic             md_ctrl_DIV,
   output logic [31:0]      md_operandA,
   output logic [31:0]      md_operandB,
   input  logic [31:0]      md_result,
   input  logic             md_exception,
   input  logic             md_resultRDY,
   // writeback side
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_result,
   output logic [4:0]       wb_rd,
   output logic             wb_exception,
   output logic             stall,
   // debug visibility
   output state_e           dbg_state_o,
   output logic [CNT_W-1:0] dbg_busy_cnt_o
);

   state_e           state_q, state_d;
   logic             op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [4:0]       rd_q, rd_d;
   logic [31:0]      res_q, res_d;
   logic             exc_q, exc_d;
   logic [CNT_W-1:0] busy_cnt;
   logic             issue_fire;
   logic             wb_fire;
   logic             timeout_hit;

   // Handshakes: a transfer happens on a cycle where valid and ready are both
   // high at the rising edge; valid never depends on ready, and flush forces
   // every ready/valid/start this block drives low in the same cycle.
   assign issue_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready));
   assign wb_valid     = !flush && (state_q == S_DONE);
   assign md_ctrl_MULT = !flush && (state_q == S_START) && (op_q == OP_MULT);
   assign md_ctrl_DIV  = !flush && (state_q == S_START) && (op_q == OP_DIV);
   assign stall        = issue_valid && !issue_ready;
   assign issue_fire   = issue_valid && issue_ready;
   assign wb_fire      = wb_valid && wb_ready;

`ifdef MULTDIV_TIMEOUT_EN
   // Fires in the BUSY cycle whose increment brings the count to TIMEOUT,
   // so DONE follows exactly TIMEOUT BUSY cycles.
   assign timeout_hit = (int'(busy_cnt) == (TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and capture logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      res_d   = res_q;
      exc_d   = exc_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue_fire) state_d = S_START;
         end
         S_START: begin
            // Any RDY shown here is left over from the previous operation.
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (md_resultRDY) begin
               state_d = S_DONE;
               res_d   = md_result;
               exc_d   = md_exception;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               res_d   = '0;
               exc_d   = 1'b1;
            end
         end
         S_DONE: begin
            if (wb_fire) state_d = issue_fire ? S_START : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (issue_fire) begin
         op_d = issue_op;
         a_d  = issue_a;
         b_d  = issue_b;
         rd_d = issue_rd;
      end
      if (flush) state_d = S_IDLE;
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_MULT;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   md_cycle_counter u_busy_cnt (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .clr_i   (state_d == S_START),
      .en_i    (state_q == S_BUSY),
      .count_o (busy_cnt)
   );

   assign md_operandA    = a_q;
   assign md_operandB    = b_q;
   assign wb_result      = res_q;
   assign wb_rd          = rd_q;
   assign wb_exception   = exc_q;
   assign dbg_state_o    = state_q;
   assign dbg_busy_cnt_o = busy_cnt;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer. Inputs change at posedge+1, outputs
// are sampled at negedge. The bench plays the multiply/divide unit itself.
module tb_multdiv_sequencer;
   import multdiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_op, flush;
   logic [31:0] issue_a, issue_b;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        md_ctrl_MULT, md_ctrl_DIV;
   logic [31:0] md_operandA, md_operandB, md_result;
   logic        md_exception, md_resultRDY;
   logic        wb_valid, wb_ready, wb_exception, stall;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;
   state_e      dbg_state;
   logic [7:0]  dbg_cnt;

   int tests = 0;
   int fails = 0;

   // expected writebacks: {result, rd, exception}
   logic [37:0] exp_q[$];

   multdiv_sequencer #(.TIMEOUT(10)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_op       (issue_op),
      .issue_a        (issue_a),
      .issue_b        (issue_b),
      .issue_rd       (issue_rd),
      .flush          (flush),
      .md_ctrl_MULT   (md_ctrl_MULT),
      .md_ctrl_DIV    (md_ctrl_DIV),
      .md_operandA    (md_operandA),
      .md_operandB    (md_operandB),
      .md_result      (md_result),
      .md_exception   (md_exception),
      .md_resultRDY   (md_resultRDY),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_result      (wb_result),
      .wb_rd          (wb_rd),
      .wb_exception   (wb_exception),
      .stall          (stall),
      .dbg_state_o    (dbg_state),
      .dbg_busy_cnt_o (dbg_cnt)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model / scoreboard ----------------
   logic        acc_pend = 1'b0;
   logic        acc_op;
   logic [31:0] acc_a, acc_b;
   logic        in_op = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_res;
   logic [4:0]  prev_rd;
   logic        prev_exc;

   // Per-cycle rule checks against the model
   always @(negedge clock) begin
      if (!reset_n) begin
         acc_pend  = 1'b0;
         in_op     = 1'b0;
         hold_prev = 1'b0;
      end else begin
         logic [37:0] e;
         chk("stall", 32'(stall), 32'(issue_valid & ~issue_ready));
         if (flush)
            chk("flush_gate", 32'({wb_valid, issue_ready, md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
         if (acc_pend && !flush) begin
            chk("start_pulse", 32'({md_ctrl_MULT, md_ctrl_DIV}), acc_op ? 32'd1 : 32'd2);
            in_op = 1'b1;
         end else if (!flush) begin
            chk("no_start", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
         end
         acc_pend = 1'b0;
         if (wb_valid || flush) in_op = 1'b0;
         if (in_op) begin
            chk("operand_a", md_operandA, acc_a);
            chk("operand_b", md_operandB, acc_b);
         end
         if (hold_prev && !flush) begin
            chk("wb_hold_valid", 32'(wb_valid), 32'd1);
            chk("wb_hold_result", wb_result, prev_res);
            chk("wb_hold_rd", 32'(wb_rd), 32'(prev_rd));
            chk("wb_hold_exc", 32'(wb_exception), 32'(prev_exc));
         end
         if (wb_valid) begin
            chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (wb_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_result", wb_result, e[37:6]);
               chk("sb_rd", 32'(wb_rd), 32'(e[5:1]));
               chk("sb_exc", 32'(wb_exception), 32'(e[0]));
            end
         end
         hold_prev = wb_valid && !wb_ready && !flush;
         prev_res  = wb_result;
         prev_rd   = wb_rd;
         prev_exc  = wb_exception;
         if (issue_valid && issue_ready) begin
            acc_pend = 1'b1;
            acc_op   = issue_op;
            acc_a    = issue_a;
            acc_b    = issue_b;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   // Present an operation; returns at posedge+1 of the START cycle.
   task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      bit ok;
      ok          = 1'b0;
      issue_valid = 1'b1;
      issue_op    = op;
      issue_a     = a;
      issue_b     = b;
      issue_rd    = rd;
      for (int i = 0; i < 20 && !ok; i++) begin
         at_neg();
         ok = issue_ready;
         next_cyc();
      end
      issue_valid = 1'b0;
      chk("issue_accept", 32'(ok), 32'd1);
   endtask

   // Unit model: RDY n cycles after START; returns in the following cycle.
   task automatic respond(input int n, input logic [31:0] res, input logic exc);
      repeat (n) begin
         next_cyc();
         md_resultRDY = 1'b0;
      end
      md_resultRDY = 1'b1;
      md_result    = res;
      md_exception = exc;
      next_cyc();
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset_n      = 1'b0;
      issue_valid  = 1'b1;
      issue_op     = OP_MULT;
      issue_a      = '0;
      issue_b      = '0;
      issue_rd     = '0;
      flush        = 1'b0;
      md_result    = '0;
      md_exception = 1'b0;
      md_resultRDY = 1'b0;
      wb_ready     = 1'b1;
      #2;
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
      chk("rst_wb_result", wb_result, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_opa", md_operandA, 32'd0);
      chk("rst_cnt", 32'(dbg_cnt), 32'd0);
      next_cyc();
      reset_n     = 1'b1;
      issue_valid = 1'b0;
      next_cyc();

      // MULT 7 * -3 -> -21, RDY 32 cycles after START
      exp_q.push_back({32'hFFFF_FFEB, 5'd5, 1'b0});
      issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 5'd5);
      at_neg();
      chk("t1_mult", 32'(md_ctrl_MULT), 32'd1);
      chk("t1_div", 32'(md_ctrl_DIV), 32'd0);
      chk("t1_opa", md_operandA, 32'd7);
      chk("t1_opb", md_operandB, 32'hFFFF_FFFD);
      respond(32, 32'hFFFF_FFEB, 1'b0);
      at_neg();
      chk("t1_wb_valid", 32'(wb_valid), 32'd1);
      chk("t1_wb_result", wb_result, 32'hFFFF_FFEB);
      chk("t1_wb_rd", 32'(wb_rd), 32'd5);
      chk("t1_wb_exc", 32'(wb_exception), 32'd0);
      chk("t1_cnt", 32'(dbg_cnt), 32'd32);
      next_cyc();
      at_neg();
      chk("t1_idle", 32'(dbg_state), 32'(S_IDLE));

      // DIV 100/7 with wb_ready low, stale RDY in START, then back-to-back DIV
      next_cyc();
      wb_ready = 1'b0;
      exp_q.push_back({32'd14, 5'd9, 1'b0});
      issue(OP_DIV, 32'd100, 32'd7, 5'd9);
      md_resultRDY = 1'b1;
      md_result    = 32'hDEAD_BEEF;
      md_exception = 1'b1;
      at_neg();
      chk("t2_div", 32'(md_ctrl_DIV), 32'd1);
      chk("t2_mult", 32'(md_ctrl_MULT), 32'd0);
      respond(5, 32'd14, 1'b0);
      exp_q.push_back({32'hFFFF_FFFF, 5'd3, 1'b1});
      issue_valid = 1'b1;
      issue_op    = OP_DIV;
      issue_a     = 32'hFFFF_FFEC;
      issue_b     = 32'd0;
      issue_rd    = 5'd3;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("t2_hold_valid", 32'(wb_valid), 32'd1);
         chk("t2_hold_result", wb_result, 32'd14);
         chk("t2_hold_rd", 32'(wb_rd), 32'd9);
         chk("t2_stall", 32'(stall), 32'd1);
         next_cyc();
      end
      wb_ready = 1'b1;
      at_neg();
      chk("t2_b2b_ready", 32'(issue_ready), 32'd1);
      next_cyc();
      issue_valid = 1'b0;
      at_neg();
      chk("t2_b2b_start", 32'(dbg_state), 32'(S_START));
      chk("t2_b2b_div", 32'(md_ctrl_DIV), 32'd1);
      chk("t2_b2b_opa", md_operandA, 32'hFFFF_FFEC);
      chk("t2_cnt_clr", 32'(dbg_cnt), 32'd0);
      respond(3, 32'hFFFF_FFFF, 1'b1);
      at_neg();
      chk("t2_exc", 32'(wb_exception), 32'd1);
      chk("t2_rd", 32'(wb_rd), 32'd3);
      next_cyc();

      // back-to-back MULTs: 6*9=54, then -2*-8=16 issued in the handshake cycle
      exp_q.push_back({32'd54, 5'd1, 1'b0});
      exp_q.push_back({32'd16, 5'd2, 1'b0});
      issue(OP_MULT, 32'd6, 32'd9, 5'd1);
      respond(4, 32'd54, 1'b0);
      issue_valid = 1'b1;
      issue_op    = OP_MULT;
      issue_a     = 32'hFFFF_FFFE;
      issue_b     = 32'hFFFF_FFF8;
      issue_rd    = 5'd2;
      at_neg();
      chk("t3_wb_valid", 32'(wb_valid), 32'd1);
      chk("t3_issue_ready", 32'(issue_ready), 32'd1);
      next_cyc();
      issue_valid = 1'b0;
      at_neg();
      chk("t3_start2", 32'(md_ctrl_MULT), 32'd1);
      chk("t3_opa2", md_operandA, 32'hFFFF_FFFE);
      respond(2, 32'd16, 1'b0);
      at_neg();
      chk("t3_result2", wb_result, 32'd16);
      next_cyc();

      // flush in BUSY, RDY one cycle later must be ignored
      issue(OP_MULT, 32'd3, 32'd4, 5'd7);
      next_cyc();
      next_cyc();
      flush = 1'b1;
      at_neg();
      chk("t4_flush_wb", 32'(wb_valid), 32'd0);
      next_cyc();
      flush        = 1'b0;
      md_resultRDY = 1'b1;
      md_result    = 32'd12;
      at_neg();
      chk("t4_idle", 32'(dbg_state), 32'(S_IDLE));
      chk("t4_ready", 32'(issue_ready), 32'd1);
      next_cyc();
      md_resultRDY = 1'b0;
      at_neg();
      chk("t4_no_wb", 32'(wb_valid), 32'd0);
      next_cyc();
      exp_q.push_back({32'd25, 5'd8, 1'b0});
      issue(OP_MULT, 32'd5, 32'd5, 5'd8);
      respond(6, 32'd25, 1'b0);
      at_neg();
      chk("t4_after", wb_result, 32'd25);
      next_cyc();

      // flush in START suppresses the start pulse
      issue(OP_DIV, 32'd9, 32'd3, 5'd12);
      flush = 1'b1;
      at_neg();
      chk("t4_start_flush", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
      next_cyc();
      flush = 1'b0;
      at_neg();
      chk("t4_start_idle", 32'(dbg_state), 32'(S_IDLE));
      next_cyc();

      // flush in DONE suppresses the writeback
      issue(OP_MULT, 32'd1, 32'd1, 5'd4);
      respond(2, 32'd1, 1'b0);
      flush = 1'b1;
      at_neg();
      chk("t4_done_flush", 32'(wb_valid), 32'd0);
      next_cyc();
      flush = 1'b0;
      at_neg();
      chk("t4_done_idle", 32'(dbg_state), 32'(S_IDLE));
      next_cyc();

      // asynchronous reset during START
      issue(OP_DIV, 32'd50, 32'd5, 5'd13);
      chk("t5_start_div", 32'(md_ctrl_DIV), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_async_div", 32'(md_ctrl_DIV), 32'd0);
      chk("t5_async_state", 32'(dbg_state), 32'(S_IDLE));
      next_cyc();
      reset_n = 1'b1;
      next_cyc();

      // asynchronous reset mid-BUSY, later RDY gives no writeback
      issue(OP_MULT, 32'd2, 32'd3, 5'd14);
      repeat (3) next_cyc();
      #1 reset_n = 1'b0;
      issue_valid = 1'b1;
      #1;
      chk("t5_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
      chk("t5_issue_ready", 32'(issue_ready), 32'd1);
      chk("t5_stall", 32'(stall), 32'd0);
      chk("t5_wb_valid", 32'(wb_valid), 32'd0);
      chk("t5_cnt", 32'(dbg_cnt), 32'd0);
      chk("t5_rd", 32'(wb_rd), 32'd0);
      chk("t5_opa", md_operandA, 32'd0);
      next_cyc();
      issue_valid  = 1'b0;
      reset_n      = 1'b1;
      md_resultRDY = 1'b1;
      md_result    = 32'd6;
      at_neg();
      chk("t5_rdy_idle", 32'(dbg_state), 32'(S_IDLE));
      next_cyc();
      md_resultRDY = 1'b0;
      at_neg();
      chk("t5_no_wb", 32'(wb_valid), 32'd0);
      next_cyc();

`ifdef MULTDIV_TIMEOUT_EN
      // timeout after 10 BUSY cycles
      exp_q.push_back({32'd0, 5'd11, 1'b1});
      issue(OP_MULT, 32'd8, 32'd8, 5'd11);
      repeat (10) next_cyc();
      at_neg();
      chk("t6_not_yet", 32'(wb_valid), 32'd0);
      next_cyc();
      at_neg();
      chk("t6_to_valid", 32'(wb_valid), 32'd1);
      chk("t6_to_result", wb_result, 32'd0);
      chk("t6_to_exc", 32'(wb_exception), 32'd1);
      chk("t6_to_cnt", 32'(dbg_cnt), 32'd10);
      next_cyc();
      // RDY coinciding with the timeout wins
      exp_q.push_back({32'd77, 5'd12, 1'b0});
      issue(OP_DIV, 32'd77, 32'd1, 5'd12);
      respond(10, 32'd77, 1'b0);
      at_neg();
      chk("t6_rdy_wins", wb_result, 32'd77);
      chk("t6_rdy_exc", 32'(wb_exception), 32'd0);
      next_cyc();
`else
      // no timeout: BUSY waits past 255 cycles, counter saturates
      exp_q.push_back({32'h0000_1234, 5'd15, 1'b0});
      issue(OP_MULT, 32'h0000_0002, 32'h0000_091A, 5'd15);
      repeat (300) next_cyc();
      at_neg();
      chk("t6_still_busy", 32'(dbg_state), 32'(S_BUSY));
      chk("t6_no_wb", 32'(wb_valid), 32'd0);
      chk("t6_sat", 32'(dbg_cnt), 32'd255);
      respond(0, 32'h0000_1234, 1'b0);
      at_neg();
      chk("t6_result", wb_result, 32'h0000_1234);
      next_cyc();
`endif

      next_cyc();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
